wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq_if.sv | 26 ++
 rtl/wide_add_seq.sv | 123 ++++++++++++
 tb/tb_wide_add_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - operand/result bundle between a requester and wide_add_seq
// ovf exists only when ADDSEQ_OVF_EN is defined.
interface wide_add_seq_if #(
  parameter int N     = 19,
  parameter int WORDS = 4
);
  localparam int TW = (N + 1) * WORDS;

  logic          start;
  logic [TW-1:0] A;
  logic [TW-1:0] B;
  logic          Ci;
  logic          busy;
  logic          done;
  logic [TW-1:0] S;
  logic          Co;
`ifdef ADDSEQ_OVF_EN
  logic          ovf;

  modport master (output start, A, B, Ci, input busy, done, S, Co, ovf);
  modport slave  (input start, A, B, Ci, output busy, done, S, Co, ovf);
`else
  modport master (output start, A, B, Ci, input busy, done, S, Co);
  modport slave  (input start, A, B, Ci, output busy, done, S, Co);
`endif
endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-word adder reusing one (N+1)-bit add-with-carry per cycle
// Define ADDSEQ_OVF_EN to add the registered signed-overflow output ovf.
module wide_add_seq #(
  parameter int N     = 19,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  wide_add_seq_if.slave bus
);
  localparam int WW = N + 1;
  localparam int TW = WW * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] a_q, a_d;
  logic [TW-1:0] b_q, b_d;
  logic [TW-1:0] s_q, s_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [WW-1:0] a_word;
  logic [WW-1:0] b_word;
  logic [WW-1:0] sum_word;
  logic          c_out;

  always_comb begin
    a_word = a_q[int'(idx_q)*WW +: WW];
    b_word = b_q[int'(idx_q)*WW +: WW];
    {c_out, sum_word} = {1'b0, a_word} + {1'b0, b_word} + {{WW{1'b0}}, carry_q};
  end

`ifdef ADDSEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_word;

  // Same-sign operands producing a different-sign sum is equivalent to
  // carry-into-MSB XOR carry-out.
  assign ovf_word = (a_word[N] == b_word[N]) && (sum_word[N] != a_word[N]);
  assign bus.ovf  = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
`ifdef ADDSEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[int'(idx_q)*WW +: WW] = sum_word;
        carry_d = c_out;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          co_d    = c_out;
`ifdef ADDSEQ_OVF_EN
          ovf_d   = ovf_word;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
`ifdef ADDSEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
`ifdef ADDSEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Co   = co_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - randomized self-checking bench for wide_add_seq against an arithmetic model
module tb_wide_add_seq;
  localparam int N     = 19;
  localparam int WORDS = 4;
  localparam int W     = (N + 1) * WORDS;
  localparam int W1    = W + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wide_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Exact signed sum; overflow when it does not fit back into W bits.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic signed [W+1:0] x;
    x = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, ci});
    return x[W] != x[W-1];
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit scramble);
    logic [W:0] exp_sum;
    logic       exp_ovf;
    exp_sum = ref_sum(a, b, ci);
    exp_ovf = ref_ovf(a, b, ci);
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy_after_accept"}, W1'({bus.done, bus.busy}), W1'(2'b01));
    if (scramble) begin
      bus.A  = rnd_word();
      bus.B  = rnd_word();
      bus.Ci = ~ci;
    end
    for (int k = 1; k <= WORDS; k++) begin
      tick();
      if (k < WORDS) begin
        check({tag, "_running"}, W1'({bus.done, bus.busy}), W1'(2'b01));
      end else begin
        check({tag, "_done_pulse"}, W1'({bus.done, bus.busy}), W1'(2'b10));
        check({tag, "_sum"}, {bus.Co, bus.S}, exp_sum);
`ifdef ADDSEQ_OVF_EN
        check({tag, "_ovf"}, W1'(bus.ovf), W1'(exp_ovf));
`endif
      end
    end
    tick();
    check({tag, "_after_done"}, W1'({bus.done, bus.busy}), W1'(2'b00));
    check({tag, "_sum_held"}, {bus.Co, bus.S}, exp_sum);
  endtask

  initial begin
    logic [W-1:0] ca, cb;
    logic         cc;
    logic [W:0]   held_exp;
    logic         saw_done;
    logic [W-1:0] all_ones;
    logic [W-1:0] max_pos;

    all_ones  = '1;
    max_pos   = {1'b0, {(W-1){1'b1}}};
    held_exp  = '0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Ci    = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    check("reset_flags", W1'({bus.done, bus.busy}), W1'(2'b00));
    check("reset_sum", {bus.Co, bus.S}, '0);
`ifdef ADDSEQ_OVF_EN
    check("reset_ovf", W1'(bus.ovf), W1'(1'b0));
`endif
    rst = 1'b0;
    tick();

    run_op("ripple", W'(1), all_ones, 1'b0, 1'b0);
    run_op("carry_in", W'(80'h12345), W'(80'h54321), 1'b1, 1'b0);
`ifdef ADDSEQ_OVF_EN
    run_op("ovf_maxpos", max_pos, W'(1), 1'b0, 1'b0);
    run_op("ovf_allones", all_ones, W'(1), 1'b0, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rand%0d", i), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), (i % 2) == 1);
    end

    // start held high: accepts land every 6 edges, operands churn every cycle.
    bus.start = 1'b1;
    for (int t = 0; t < 18; t++) begin
      ca = rnd_word();
      cb = rnd_word();
      cc = 1'($urandom_range(0, 1));
      bus.A  = ca;
      bus.B  = cb;
      bus.Ci = cc;
      if (t % 6 == 0) held_exp = ref_sum(ca, cb, cc);
      tick();
      check($sformatf("held_done_t%0d", t), W1'(bus.done), W1'((t % 6) == 4));
      if (t % 6 == 4) check($sformatf("held_sum_t%0d", t), {bus.Co, bus.S}, held_exp);
    end
    bus.start = 1'b0;

    bus.A     = rnd_word() | W'(1);
    bus.B     = '0;
    bus.Ci    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_flags", W1'({bus.done, bus.busy}), W1'(2'b00));
    check("midrun_rst_sum", {bus.Co, bus.S}, '0);
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw_done = saw_done | bus.done;
    end
    check("midrun_no_done", W1'(saw_done), W1'(1'b0));

    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_over_start", W1'(bus.busy), W1'(1'b0));
    tick();
    check("rst_over_start_idle", W1'(bus.busy), W1'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
